wb_regfile: RTL
===============

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter BYPASS_EN, default 1, meaning a same-cycle write-to-read bypass is enabled.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port WB_cntl_RegWrite  in  1  register write enable from the MEM/WB register.
REQ-005 SHALL have port WB_sel_MemToReg  in  3  writeback source: 000 ALUResult, 001 load data, 010 immediate, 011 BranchAddr, 100 PC+4.
REQ-006 SHALL have port WB_funct  in  3  load funct3.
REQ-007 SHALL have ports WB_ReadMemData, WB_ALUResult, WB_immediate  in  32 each; WB_PCplus4, WB_BranchAddr  in  20 each.
REQ-008 SHALL have port WB_WriteRegNum  in  5  destination register.
REQ-009 SHALL have ports rs1_num, rs2_num  in  5 each  ID-stage read addresses.
REQ-010 SHALL have ports rs1_data, rs2_data  out  32 each  ID-stage read data.
REQ-011 SHALL have port WB_WriteData  out  32  selected writeback value, also the forwarding source for EX.

Function
REQ-012 SHALL compute WB_WriteData combinationally from WB_sel_MemToReg; WB_PCplus4 and WB_BranchAddr SHALL be zero-extended to 32 bits; codes 101-111 SHALL select WB_ALUResult.
REQ-013 SHALL take the load lane from WB_ALUResult[1:0] on the full 32-bit WB_ReadMemData word.
REQ-014 SHALL apply WB_funct as follows: 000 LB sign-extends byte[addr*8+:8]; 001 LH sign-extends half[addr[1]*16+:16]; 010 LW returns the word; 100 LBU zero-extends the byte; 101 LHU zero-extends the half; 011/110/111 return the word unmodified.
REQ-015 SHALL hold 31 x 32-bit registers x1..x31; x0 SHALL always read 0 and SHALL never be stored.
REQ-016 SHALL write WB_WriteData into x[WB_WriteRegNum] on the rising clk edge when WB_cntl_RegWrite=1 and WB_WriteRegNum!=0; write latency is one edge.
REQ-017 SHALL make reads combinational with zero latency.
REQ-018 With BYPASS_EN=1, a read port whose number equals WB_WriteRegNum SHALL return WB_WriteData in the same cycle when WB_cntl_RegWrite=1 and the number is nonzero; otherwise it SHALL return the stored value.
REQ-019 With BYPASS_EN=0, reads SHALL return the stored value only.
REQ-020 Both read ports SHALL bypass independently when rs1_num==rs2_num==WB_WriteRegNum.
REQ-021 WB_WriteRegNum=0 with WB_cntl_RegWrite=1 SHALL neither change state nor bypass.
REQ-022 WB_cntl_RegWrite=0 SHALL leave all registers unchanged whatever the other inputs are.

Reset
REQ-023 reset_n low SHALL asynchronously clear x1..x31 to 0.
REQ-024 While reset_n is low, rs1_data and rs2_data SHALL read 0.
REQ-025 A write coinciding with reset assertion SHALL be discarded.
REQ-026 The first write SHALL occur on the first rising edge after reset_n rises.

Structure
REQ-027 The MemToReg encodings (000-100) and load funct3 constants SHALL reside in shared package rv32i_pkg.
REQ-028 Lane selection and extension SHALL be one combinational sub-module, wb_load_align; register storage, write and bypass SHALL remain in wb_regfile.

Verification
REQ-029 Write x5 from ALUResult=0x12345678, sel=000, then read rs1=5 next cycle -> rs1_data=0x12345678.
REQ-030 sel=001, funct=000, ReadMemData=0x80FF7F01, ALUResult[1:0]=2'b11 -> WB_WriteData=0xFFFFFF80; funct=100 -> 0x00000080; funct=101 with addr[1]=1 -> 0x000080FF.
REQ-031 Write x0=0xDEADBEEF with rs1=rs2=0 -> rs1_data=rs2_data=0 in the same cycle and afterwards.
REQ-032 BYPASS_EN=1, write x7=0xA5A5A5A5 (sel=010) with rs1=rs2=7 in the same cycle -> both read 0xA5A5A5A5 before the edge; repeat with BYPASS_EN=0 -> old value before the edge, new value after it.
REQ-033 sel=100, PCplus4=0xFFFFC -> WB_WriteData=0x000FFFFC; sel=111 -> WB_ALUResult.
REQ-034 Fill x1..x31 with nonzero values, pulse reset_n low mid-cycle -> all reads return 0 immediately and remain 0 after release.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I writeback encodings.
//   MemToReg select codes (000-100) chosen in the MEM/WB stage.
//   Load funct3 codes that control lane extension of load data.
package rv32i_pkg;

  // Writeback source select (WB_sel_MemToReg); 101-111 fall back to ALU result
  localparam logic [2:0] SEL_ALU    = 3'b000;
  localparam logic [2:0] SEL_LOAD   = 3'b001;
  localparam logic [2:0] SEL_IMM    = 3'b010;
  localparam logic [2:0] SEL_BRANCH = 3'b011;
  localparam logic [2:0] SEL_PC4    = 3'b100;

  // Load funct3; 011/110/111 pass the word through unmodified
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: combinational load lane selection and extension.
// Ports:
//   mem_word  in  32  full word read from data memory
//   addr      in  2   byte offset within the word (ALU result [1:0])
//   funct     in  3   load funct3
//   load_data out 32  aligned, extended load value
module wb_load_align
  import rv32i_pkg::*;
(
  input  logic [31:0] mem_word,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_word[7:0];
    case (addr)
      2'd0: byte_sel = mem_word[7:0];
      2'd1: byte_sel = mem_word[15:8];
      2'd2: byte_sel = mem_word[23:16];
      2'd3: byte_sel = mem_word[31:24];
      default: byte_sel = mem_word[7:0];
    endcase
    // Halfword lane uses only addr[1]; addr[0] is ignored
    half_sel = addr[1] ? mem_word[31:16] : mem_word[15:0];
  end

  always_comb begin
    load_data = mem_word;
    case (funct)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LW:   load_data = mem_word;
      F3_LBU:  load_data = {24'd0, byte_sel};
      F3_LHU:  load_data = {16'd0, half_sel};
      default: load_data = mem_word;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: RV32I writeback mux plus 31x32 integer register file.
// Ports:
//   clk, reset_n                    clock, async active-low reset
//   WB_cntl_RegWrite                write enable from MEM/WB
//   WB_sel_MemToReg                 writeback source select
//   WB_funct                        load funct3
//   WB_ReadMemData/ALUResult/immediate  32-bit writeback sources
//   WB_PCplus4/WB_BranchAddr        20-bit sources, zero-extended
//   WB_WriteRegNum                  destination register
//   rs1_num/rs2_num                 ID-stage read addresses
//   rs1_data/rs2_data               ID-stage read data (combinational)
//   WB_WriteData                    selected writeback value / EX forward source
module wb_regfile
  import rv32i_pkg::*;
#(
  parameter bit BYPASS_EN = 1'b1
)
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        WB_cntl_RegWrite,
  input  logic [2:0]  WB_sel_MemToReg,
  input  logic [2:0]  WB_funct,
  input  logic [31:0] WB_ReadMemData,
  input  logic [31:0] WB_ALUResult,
  input  logic [31:0] WB_immediate,
  input  logic [19:0] WB_PCplus4,
  input  logic [19:0] WB_BranchAddr,
  input  logic [4:0]  WB_WriteRegNum,
  input  logic [4:0]  rs1_num,
  input  logic [4:0]  rs2_num,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] WB_WriteData
);

  logic [31:0] load_data;
  logic [31:0] regs [1:31];
  logic        write_en;

  wb_load_align u_load_align (
    .mem_word  (WB_ReadMemData),
    .addr      (WB_ALUResult[1:0]),
    .funct     (WB_funct),
    .load_data (load_data)
  );

  always_comb begin
    WB_WriteData = WB_ALUResult;
    case (WB_sel_MemToReg)
      SEL_ALU:    WB_WriteData = WB_ALUResult;
      SEL_LOAD:   WB_WriteData = load_data;
      SEL_IMM:    WB_WriteData = WB_immediate;
      SEL_BRANCH: WB_WriteData = {12'd0, WB_BranchAddr};
      SEL_PC4:    WB_WriteData = {12'd0, WB_PCplus4};
      default:    WB_WriteData = WB_ALUResult;
    endcase
  end

  // x0 is never stored; writes to it are dropped here
  assign write_en = WB_cntl_RegWrite && (WB_WriteRegNum != 5'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (write_en) begin
      regs[WB_WriteRegNum] <= WB_WriteData;
    end
  end

  // Reads: x0 -> 0, optional same-cycle bypass, forced 0 while in reset
  // so a pending write cannot leak through the bypass.
  always_comb begin
    rs1_data = '0;
    if (rs1_num != 5'd0) begin
      if (BYPASS_EN && write_en && (rs1_num == WB_WriteRegNum))
        rs1_data = WB_WriteData;
      else
        rs1_data = regs[rs1_num];
    end
    if (!reset_n) rs1_data = '0;
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_num != 5'd0) begin
      if (BYPASS_EN && write_en && (rs2_num == WB_WriteRegNum))
        rs2_data = WB_WriteData;
      else
        rs2_data = regs[rs2_num];
    end
    if (!reset_n) rs2_data = '0;
  end

endmodule
